// File: rtl/mux_rr_pipe_pkg.sv
// Shared defaults and encodings for the mux_rr_pipe slice.
//   DATA_WIDTH_DEF / NUM_IN_DEF : default channel width and channel count
//   mode_e                      : MODE input encoding (explicit select / round-robin)
//   ptr_rst()                   : round-robin pointer reset value
package mux_rr_pipe_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_IN_DEF     = 16;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Pointer parks on the last channel so the first search begins at channel 0.
  function automatic int ptr_rst(input int num_in);
    return num_in - 1;
  endfunction
endpackage

// File: rtl/mux_rr_pipe_if.sv
// Channel-side and output-side bus of mux_rr_pipe.
//   MODE, S, I, IN_VALID / IN_READY : input channels and select control
//   Y, Y_SEL, Y_VALID / Y_READY     : registered output word and its handshake
// master = the environment, slave = the mux.
interface mux_rr_pipe_if
  import mux_rr_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = NUM_IN_DEF
);
  localparam int SEL_WIDTH = $clog2(NUM_IN);

  logic                         MODE;
  logic [SEL_WIDTH-1:0]         S;
  logic [NUM_IN*DATA_WIDTH-1:0] I;
  logic [NUM_IN-1:0]            IN_VALID;
  logic [NUM_IN-1:0]            IN_READY;
  logic [DATA_WIDTH-1:0]        Y;
  logic [SEL_WIDTH-1:0]         Y_SEL;
  logic                         Y_VALID;
  logic                         Y_READY;

  modport master (
    output MODE, S, I, IN_VALID, Y_READY,
    input  IN_READY, Y, Y_SEL, Y_VALID
  );
  modport slave (
    input  MODE, S, I, IN_VALID, Y_READY,
    output IN_READY, Y, Y_SEL, Y_VALID
  );
endinterface

// File: rtl/mux_rr_pipe_rr_grant_n.sv
// Round-robin priority search.
//   valid   : per-channel request
//   ptr     : last granted channel; search starts at ptr+1 and wraps
//   gnt     : first requesting channel found
//   gnt_vld : some channel is requesting
module rr_grant_n #(
  parameter int NUM_IN    = 16,
  parameter int SEL_WIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    valid,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] gnt,
  output logic                 gnt_vld
);
  logic [SEL_WIDTH-1:0] idx;

  // Walk from the farthest offset to the nearest so the nearest requester
  // wins. NUM_IN is a power of two, so SEL_WIDTH truncation is the wrap.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = ptr + SEL_WIDTH'(k);
      if (valid[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_pipe.sv
// N-to-1 mux with one output register, explicit or round-robin selection.
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : mux_rr_pipe_if slave (MODE, S, I, IN_VALID/IN_READY,
//              Y, Y_SEL, Y_VALID/Y_READY)
// Y/Y_SEL/Y_VALID are registered; IN_READY is the only combinational output.
module mux_rr_pipe
  import mux_rr_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = NUM_IN_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  mux_rr_pipe_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(NUM_IN);

  logic [SEL_WIDTH-1:0] ptr, rr_gnt, gnt;
  logic                 rr_vld, gnt_vld, load;

  rr_grant_n #(.NUM_IN(NUM_IN), .SEL_WIDTH(SEL_WIDTH)) u_rr (
    .valid   (bus.IN_VALID),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // Explicit mode never falls back to another channel.
  always_comb begin
    gnt     = bus.S;
    gnt_vld = bus.IN_VALID[bus.S];
    if (mode_e'(bus.MODE) == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end
  end

  // RST gates load so nothing is accepted while reset is held.
  assign load = RST && gnt_vld && (!bus.Y_VALID || bus.Y_READY);

  always_comb begin
    bus.IN_READY = '0;
    if (load) bus.IN_READY[gnt] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.Y       <= '0;
      bus.Y_SEL   <= '0;
      bus.Y_VALID <= 1'b0;
      ptr         <= SEL_WIDTH'(ptr_rst(NUM_IN));
    end else if (load) begin
      bus.Y       <= bus.I[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
      bus.Y_SEL   <= gnt;
      bus.Y_VALID <= 1'b1;
      ptr         <= gnt;
    end else if (bus.Y_READY) begin
      // Word taken with nothing to replace it; data/index hold last value.
      bus.Y_VALID <= 1'b0;
    end
  end
endmodule

// File: doc/mux_rr_pipe.md
MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each data channel.
REQ-002 SHALL have parameter NUM_IN, default 16: input channel count, power of two, 2..16.
REQ-003 SHALL have derived parameter SEL_WIDTH = clog2(NUM_IN): selector/index width.
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port MODE  input  1  0 = explicit select via S, 1 = round-robin.
REQ-007 SHALL have port S  input  SEL_WIDTH  explicit channel select, used only when MODE=0.
REQ-008 SHALL have port I  input  NUM_IN*DATA_WIDTH  flattened data; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port IN_VALID  input  NUM_IN  per-channel valid.
REQ-010 SHALL have port IN_READY  output  NUM_IN  per-channel accept, one-hot or zero.
REQ-011 SHALL have port Y  output  DATA_WIDTH  registered selected data.
REQ-012 SHALL have port Y_SEL  output  SEL_WIDTH  index of the channel held in Y.
REQ-013 SHALL have port Y_VALID  output  1  Y/Y_SEL hold an untaken word.
REQ-014 SHALL have port Y_READY  input  1  downstream accepts Y this cycle.

Function
REQ-015 Output register SHALL load when (Y_VALID=0 or Y_READY=1) and a grant exists; latency input-to-Y is exactly 1 cycle.
REQ-016 When the register is full and Y_READY=0, IN_READY SHALL be all zero and Y, Y_SEL, Y_VALID SHALL hold.
REQ-017 When Y_READY=1 and no grant exists, Y_VALID SHALL clear next cycle; Y and Y_SEL SHALL hold their last value.
REQ-018 MODE=0: grant = S iff IN_VALID[S]=1; otherwise no grant (no fallback to other channels).
REQ-019 MODE=1: grant = first k with IN_VALID[k]=1 searching (PTR+1) mod NUM_IN upward with wrap-around.
REQ-020 PTR (SEL_WIDTH bits) SHALL update to the granted index only on a transfer (load of the output register), in either mode.
REQ-021 IN_READY[g] SHALL be 1 only for the granted channel g in a load cycle; a handshake occurs iff IN_VALID[g] and IN_READY[g].
REQ-022 Sustained throughput SHALL be one word per cycle while Y_READY=1 and a grant exists.
REQ-023 MODE or S changes SHALL affect only the combinational grant of the current cycle; the word already in Y is unaffected.
REQ-024 Combinational paths SHALL exist only from MODE, S, IN_VALID, Y_VALID, Y_READY, PTR to IN_READY; Y, Y_SEL, Y_VALID SHALL be purely registered.

Reset
REQ-025 RST=0 SHALL asynchronously force Y=0, Y_SEL=0, Y_VALID=0, PTR=NUM_IN-1 (so the first round-robin search starts at channel 0).
REQ-026 While RST=0, IN_READY SHALL be all zero; a word in flight when reset asserts SHALL be discarded.
REQ-027 After RST deasserts, the first load SHALL occur no earlier than the first rising CLK edge with RST=1.

Structure
REQ-028 A shared package SHALL hold DATA_WIDTH and NUM_IN defaults, the MODE encodings (MODE_SEL=0, MODE_RR=1) and the PTR reset value.
REQ-029 The round-robin priority search SHALL be a sub-module rr_grant_n (inputs IN_VALID, PTR; outputs grant index and grant-valid).
REQ-030 The data select SHALL be an indexed part-select of I; no per-width hand-built mux trees.

Verification
REQ-031 Explicit: MODE=0, I[k]=k, all IN_VALID=1, Y_READY=1, S sweeps 0..15 one per cycle -> Y equals S of the previous cycle, Y_SEL=Y, Y_VALID=1 throughout.
REQ-032 Missing valid: MODE=0, S=5, IN_VALID=16'hFFDF -> IN_READY=0, Y_VALID drops to 0 the next cycle; then set IN_VALID[5]=1 -> Y=5 one cycle later.
REQ-033 Round-robin: MODE=1, IN_VALID=16'h8421 held, Y_READY=1 -> Y_SEL sequence 0,5,10,15,0,5, one per cycle.
REQ-034 Backpressure: MODE=1, all valid, Y_READY=0 for 3 cycles after first load -> Y_SEL stays 0, IN_READY=0; on release, next Y_SEL=1 with no channel skipped.
REQ-035 Reset mid-stream: RST pulsed low between clock edges during REQ-033 traffic -> Y=0, Y_VALID=0 immediately; first post-reset grant is channel 0.
REQ-036 Parameter sweep: NUM_IN=2, DATA_WIDTH=8 and NUM_IN=4, DATA_WIDTH=32 rerun REQ-031 and REQ-033 -> same ordering with wrap at NUM_IN-1.
